// File: rtl/lvds_bert_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_bert_pkg
//  Purpose  : Shared definitions for the LVDS BERT test sequencer. Contains
//             counter widths, window clamp, default timing parameters,
//             sequencer state encoding and a window-clamp helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lvds_bert_pkg;

  localparam int RECV_W         = 58;
  localparam int ERR_W          = 64;
  localparam int WIN_MAX        = 57;
  localparam int DEF_CLR_CYC    = 4;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_TIMEOUT_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4
  } bert_state_t;

  // A window wider than the receive counter can represent is meaningless,
  // so oversize requests saturate at the largest usable exponent.
  function automatic logic [5:0] clamp_win(input logic [5:0] w);
    return (w > 6'(WIN_MAX)) ? 6'(WIN_MAX) : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_stall_timer.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_stall_timer
//  Purpose  : No-progress detector for the received-word counter. Restarts
//             whenever the counter moves, otherwise counts up while enabled
//             and raises fire once the count reaches all-ones.
//  Ports    : CLKF   in  clock
//             RSTXF  in  asynchronous active-low reset
//             en     in  count while high
//             clr    in  force the stall count to zero
//             cnt_in in  monitored free-running counter
//             fire   out stall limit reached (only while enabled)
//  Revision : 1.0  initial release
// ============================================================================
module lvds_stall_timer #(
  parameter int TIMEOUT_W = 24,
  parameter int CNT_W     = 58
) (
  input  logic             CLKF,
  input  logic             RSTXF,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             fire
);

  logic [CNT_W-1:0]     prev_cnt;
  logic [TIMEOUT_W-1:0] stall_cnt;

  assign fire = en && (&stall_cnt);

  always_ff @(posedge CLKF or negedge RSTXF) begin
    if (!RSTXF) begin
      prev_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      prev_cnt <= cnt_in;
      if (clr || (cnt_in != prev_cnt)) begin
        stall_cnt <= '0;
      end else if (en && !fire) begin
        // Saturate at all-ones so fire stays asserted until cleared.
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lvds_bert_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_bert_ctrl
//  Purpose  : BERT run sequencer downstream of the LVDS loopback link.
//             Pulses CLR, settles, samples base counts, waits for a window
//             of 2^WIN_LOG2 received words (or a receive stall), snapshots
//             the error/receive deltas and reports PASS/TIMEOUT.
//  Ports    : CLKF, RSTXF         clock, async active-low reset
//             START, ABORT        run request / cancel (ABORT has priority)
//             WIN_LOG2, ERR_THR   window exponent, tolerated error count
//             ERR_CNT, RECV_CNT   free-running counters from the link
//             CLR, BUSY, DONE     link clear, run active, result valid
//             PASS, TIMEOUT       verdict flags
//             ERR_SNAP, RECV_SNAP deltas captured over the window
//  Revision : 1.0  initial release
// ============================================================================
module lvds_bert_ctrl
  import lvds_bert_pkg::*;
#(
  parameter int CLR_CYC    = DEF_CLR_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int TIMEOUT_W  = DEF_TIMEOUT_W
) (
  input  logic              CLKF,
  input  logic              RSTXF,
  input  logic              START,
  input  logic              ABORT,
  input  logic [5:0]        WIN_LOG2,
  input  logic [31:0]       ERR_THR,
  input  logic [ERR_W-1:0]  ERR_CNT,
  input  logic [RECV_W-1:0] RECV_CNT,
  output logic              CLR,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic              TIMEOUT,
  output logic [ERR_W-1:0]  ERR_SNAP,
  output logic [RECV_W-1:0] RECV_SNAP
);

  localparam int PH_W = 16;

  bert_state_t       state, state_nx;
  logic [PH_W-1:0]   phase, phase_nx;
  logic [5:0]        win, win_nx;
  logic [31:0]       thr, thr_nx;
  logic [ERR_W-1:0]  base_err, base_err_nx, err_snap_nx;
  logic [RECV_W-1:0] base_recv, base_recv_nx, recv_snap_nx;
  logic              clr_nx, busy_nx, done_nx, pass_nx, timeout_nx;

  logic [RECV_W-1:0] d_recv, win_thr;
  logic [ERR_W-1:0]  d_err;
  logic              run_active, stall_fire;

  // Modular differences: counter wrap between base and now is harmless.
  assign d_recv     = RECV_CNT - base_recv;
  assign d_err      = ERR_CNT - base_err;
  assign win_thr    = {{(RECV_W-1){1'b0}}, 1'b1} << win;
  assign run_active = (state == ST_RUN);

  lvds_stall_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .CNT_W     (RECV_W)
  ) u_stall (
    .CLKF   (CLKF),
    .RSTXF  (RSTXF),
    .en     (run_active),
    .clr    (!run_active),
    .cnt_in (RECV_CNT),
    .fire   (stall_fire)
  );

  always_ff @(posedge CLKF or negedge RSTXF) begin
    if (!RSTXF) begin
      state     <= ST_IDLE;
      phase     <= '0;
      win       <= '0;
      thr       <= '0;
      base_err  <= '0;
      base_recv <= '0;
      CLR       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      TIMEOUT   <= 1'b0;
      ERR_SNAP  <= '0;
      RECV_SNAP <= '0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      win       <= win_nx;
      thr       <= thr_nx;
      base_err  <= base_err_nx;
      base_recv <= base_recv_nx;
      CLR       <= clr_nx;
      BUSY      <= busy_nx;
      DONE      <= done_nx;
      PASS      <= pass_nx;
      TIMEOUT   <= timeout_nx;
      ERR_SNAP  <= err_snap_nx;
      RECV_SNAP <= recv_snap_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    phase_nx     = phase;
    win_nx       = win;
    thr_nx       = thr;
    base_err_nx  = base_err;
    base_recv_nx = base_recv;
    clr_nx       = CLR;
    busy_nx      = BUSY;
    done_nx      = DONE;
    pass_nx      = PASS;
    timeout_nx   = TIMEOUT;
    err_snap_nx  = ERR_SNAP;
    recv_snap_nx = RECV_SNAP;

    case (state)
      ST_IDLE: begin
        if (ABORT) begin
          done_nx = 1'b0;
        end else if (START) begin
          win_nx     = clamp_win(WIN_LOG2);
          thr_nx     = ERR_THR;
          done_nx    = 1'b0;
          pass_nx    = 1'b0;
          timeout_nx = 1'b0;
          clr_nx     = 1'b1;
          busy_nx    = 1'b1;
          phase_nx   = '0;
          state_nx   = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        if (phase == PH_W'(CLR_CYC - 1)) begin
          clr_nx   = 1'b0;
          phase_nx = '0;
          state_nx = ST_SETTLE;
        end else begin
          phase_nx = phase + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (phase == PH_W'(SETTLE_CYC - 1)) begin
          base_err_nx  = ERR_CNT;
          base_recv_nx = RECV_CNT;
          phase_nx     = '0;
          state_nx     = ST_RUN;
        end else begin
          phase_nx = phase + 1'b1;
        end
      end

      ST_RUN: begin
        // Window completion is checked first so it wins over a stall
        // firing in the same cycle.
        if (d_recv >= win_thr) begin
          err_snap_nx  = d_err;
          recv_snap_nx = d_recv;
          state_nx     = ST_FINISH;
        end else if (stall_fire) begin
          err_snap_nx  = d_err;
          recv_snap_nx = d_recv;
          timeout_nx   = 1'b1;
          state_nx     = ST_FINISH;
        end
      end

      ST_FINISH: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        pass_nx  = !TIMEOUT && (ERR_SNAP <= {{(ERR_W-32){1'b0}}, thr});
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Cancel overrides any progress in the active phases; snapshots keep
    // whatever the last completed run captured.
    if (ABORT && (state == ST_CLEAR || state == ST_SETTLE || state == ST_RUN)) begin
      state_nx = ST_IDLE;
      phase_nx = '0;
      clr_nx   = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      pass_nx  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lvds_bert_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lvds_bert_ctrl
//  Purpose  : Directed self-checking bench for lvds_bert_ctrl
//             (CLR_CYC=4, SETTLE_CYC=16, TIMEOUT_W=6).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lvds_bert_ctrl;

  logic        CLKF;
  logic        RSTXF;
  logic        START;
  logic        ABORT;
  logic [5:0]  WIN_LOG2;
  logic [31:0] ERR_THR;
  logic [63:0] ERR_CNT;
  logic [57:0] RECV_CNT;
  logic        CLR, BUSY, DONE, PASS, TIMEOUT;
  logic [63:0] ERR_SNAP;
  logic [57:0] RECV_SNAP;

  int total;
  int bad;
  bit recv_run;

  lvds_bert_ctrl #(
    .CLR_CYC    (4),
    .SETTLE_CYC (16),
    .TIMEOUT_W  (6)
  ) dut (
    .CLKF      (CLKF),
    .RSTXF     (RSTXF),
    .START     (START),
    .ABORT     (ABORT),
    .WIN_LOG2  (WIN_LOG2),
    .ERR_THR   (ERR_THR),
    .ERR_CNT   (ERR_CNT),
    .RECV_CNT  (RECV_CNT),
    .CLR       (CLR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .PASS      (PASS),
    .TIMEOUT   (TIMEOUT),
    .ERR_SNAP  (ERR_SNAP),
    .RECV_SNAP (RECV_SNAP)
  );

  initial CLKF = 1'b0;
  always #5 CLKF = ~CLKF;

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLKF);
    #1;
    if (recv_run) RECV_CNT = RECV_CNT + 58'd1;
  endtask

  // Issue START (accepted at edge e0), then scramble the inputs that
  // should have been latched.
  task automatic start_run(input logic [5:0] w, input logic [31:0] t);
    WIN_LOG2 = w;
    ERR_THR  = t;
    START    = 1'b1;
    step();
    START    = 1'b0;
    WIN_LOG2 = 6'd0;
    ERR_THR  = 32'hFFFF_FFFF;
  endtask

  // Steps until DONE; cyc counts edges after e0, clr_hi counts CLR-high samples.
  task automatic wait_done(input int budget, input int inj0, input int inj1, input int inj2,
                           input int freeze_at, input int jump_at, input logic [57:0] jump_val,
                           output int cyc, output int clr_hi);
    cyc    = 0;
    clr_hi = (CLR === 1'b1) ? 1 : 0;
    while (DONE !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
      if (CLR === 1'b1) clr_hi++;
      if (cyc == inj0 || cyc == inj1 || cyc == inj2) ERR_CNT = ERR_CNT + 64'd1;
      if (cyc == freeze_at) recv_run = 1'b0;
      if (cyc == jump_at) RECV_CNT = RECV_CNT + jump_val;
    end
    total++;
    if (DONE !== 1'b1) begin
      bad++;
      $display("FAIL done_wait DONE=%b expected 1 within %0d cycles", DONE, budget);
    end
  endtask

  task automatic test_reset();
    RSTXF = 1'b0;
    step();
    step();
    total++;
    if ({CLR, BUSY, DONE, PASS, TIMEOUT} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000", {CLR, BUSY, DONE, PASS, TIMEOUT});
    end
    total++;
    if (ERR_SNAP !== 64'd0 || RECV_SNAP !== 58'd0) begin
      bad++;
      $display("FAIL reset_snaps got err=%0d recv=%0d exp=0/0", ERR_SNAP, RECV_SNAP);
    end
    #3 RSTXF = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int cyc, clr_hi;
    recv_run = 1'b1;
    RECV_CNT = 58'd100;
    ERR_CNT  = 64'd5;
    start_run(6'd4, 32'd0);
    total++;
    if (CLR !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL basic_start CLR/BUSY/DONE got=%b%b%b exp=110", CLR, BUSY, DONE);
    end
    wait_done(200, -1, -1, -1, -1, -1, 58'd0, cyc, clr_hi);
    total++;
    if (clr_hi != 4) begin
      bad++;
      $display("FAIL basic_clr_len got=%0d exp=4", clr_hi);
    end
    total++;
    if (cyc != 37) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=37", cyc);
    end
    total++;
    if (RECV_SNAP !== 58'd16 || ERR_SNAP !== 64'd0) begin
      bad++;
      $display("FAIL basic_snaps got recv=%0d err=%0d exp=16/0", RECV_SNAP, ERR_SNAP);
    end
    total++;
    if (PASS !== 1'b1 || TIMEOUT !== 1'b0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL basic_verdict PASS/TIMEOUT/BUSY got=%b%b%b exp=100", PASS, TIMEOUT, BUSY);
    end
  endtask

  task automatic test_errors();
    int cyc, clr_hi;
    start_run(6'd8, 32'd2);
    wait_done(600, 25, 30, 40, -1, -1, 58'd0, cyc, clr_hi);
    total++;
    if (ERR_SNAP !== 64'd3 || RECV_SNAP !== 58'd256) begin
      bad++;
      $display("FAIL err_snaps got err=%0d recv=%0d exp=3/256", ERR_SNAP, RECV_SNAP);
    end
    total++;
    if (PASS !== 1'b0 || TIMEOUT !== 1'b0) begin
      bad++;
      $display("FAIL err_verdict PASS/TIMEOUT got=%b%b exp=00", PASS, TIMEOUT);
    end
  endtask

  task automatic test_timeout();
    int cyc, clr_hi;
    start_run(6'd4, 32'd100);
    wait_done(300, -1, -1, -1, 19, -1, 58'd0, cyc, clr_hi);
    total++;
    if (TIMEOUT !== 1'b1 || PASS !== 1'b0 || DONE !== 1'b1) begin
      bad++;
      $display("FAIL to_flags TIMEOUT/PASS/DONE got=%b%b%b exp=101", TIMEOUT, PASS, DONE);
    end
    total++;
    if (cyc != 85) begin
      bad++;
      $display("FAIL to_latency got=%0d exp=85", cyc);
    end
    total++;
    if (RECV_SNAP !== 58'd0 || ERR_SNAP !== 64'd0) begin
      bad++;
      $display("FAIL to_snaps got recv=%0d err=%0d exp=0/0", RECV_SNAP, ERR_SNAP);
    end
    recv_run = 1'b1;
  endtask

  task automatic test_wrap();
    int cyc, clr_hi;
    // Base lands on 2^58-5 (sampled 20 edges after START); error base 2^64-2.
    RECV_CNT = 58'd0 - 58'd25;
    ERR_CNT  = 64'd0 - 64'd2;
    start_run(6'd4, 32'd3);
    wait_done(200, 25, 26, 27, -1, -1, 58'd0, cyc, clr_hi);
    total++;
    if (RECV_SNAP !== 58'd16 || ERR_SNAP !== 64'd3) begin
      bad++;
      $display("FAIL wrap_snaps got recv=%0d err=%0d exp=16/3", RECV_SNAP, ERR_SNAP);
    end
    total++;
    if (PASS !== 1'b1 || TIMEOUT !== 1'b0) begin
      bad++;
      $display("FAIL wrap_verdict PASS/TIMEOUT got=%b%b exp=10", PASS, TIMEOUT);
    end
  endtask

  task automatic test_abort();
    int cyc, clr_hi;
    start_run(6'd8, 32'd0);
    for (int i = 0; i < 30; i++) step();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    total++;
    if ({CLR, BUSY, DONE, PASS} !== 4'b0) begin
      bad++;
      $display("FAIL abort_flags CLR/BUSY/DONE/PASS got=%b exp=0000", {CLR, BUSY, DONE, PASS});
    end
    total++;
    if (RECV_SNAP !== 58'd16 || ERR_SNAP !== 64'd3) begin
      bad++;
      $display("FAIL abort_snaps got recv=%0d err=%0d exp=16/3", RECV_SNAP, ERR_SNAP);
    end
    for (int i = 0; i < 300; i++) step();
    total++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle DONE/BUSY got=%b%b exp=00", DONE, BUSY);
    end
    // Short window-of-one run to get DONE=1 again.
    start_run(6'd0, 32'd0);
    wait_done(100, -1, -1, -1, -1, -1, 58'd0, cyc, clr_hi);
    total++;
    if (cyc != 22 || RECV_SNAP !== 58'd1 || PASS !== 1'b1) begin
      bad++;
      $display("FAIL win0_run got cyc=%0d recv=%0d pass=%b exp=22/1/1", cyc, RECV_SNAP, PASS);
    end
    START = 1'b1;
    ABORT = 1'b1;
    step();
    START = 1'b0;
    ABORT = 1'b0;
    step();
    total++;
    if ({CLR, BUSY, DONE} !== 3'b0 || RECV_SNAP !== 58'd1) begin
      bad++;
      $display("FAIL start_abort got CLR/BUSY/DONE=%b recv=%0d exp=000/1", {CLR, BUSY, DONE}, RECV_SNAP);
    end
  endtask

  task automatic test_clamp_reset();
    int cyc, clr_hi;
    ERR_CNT = 64'd77;
    start_run(6'd63, 32'd0);
    wait_done(100, -1, -1, -1, -1, 25, (58'd1 << 57) - 58'd11, cyc, clr_hi);
    total++;
    if (RECV_SNAP !== (58'd1 << 57) || cyc != 32) begin
      bad++;
      $display("FAIL clamp_win got recv=%0h cyc=%0d exp=%0h/32", RECV_SNAP, cyc, 58'd1 << 57);
    end
    total++;
    if (PASS !== 1'b1 || ERR_SNAP !== 64'd0) begin
      bad++;
      $display("FAIL clamp_verdict got pass=%b err=%0d exp=1/0", PASS, ERR_SNAP);
    end
    start_run(6'd4, 32'd0);
    step();
    #2 RSTXF = 1'b0;
    #1;
    total++;
    if ({CLR, BUSY, DONE, PASS, TIMEOUT} !== 5'b0 || ERR_SNAP !== 64'd0 || RECV_SNAP !== 58'd0) begin
      bad++;
      $display("FAIL async_reset got flags=%b err=%0d recv=%0d exp=0", {CLR, BUSY, DONE, PASS, TIMEOUT}, ERR_SNAP, RECV_SNAP);
    end
    #2 RSTXF = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++;
    if ({CLR, BUSY, DONE} !== 3'b0) begin
      bad++;
      $display("FAIL post_reset_idle CLR/BUSY/DONE got=%b exp=000", {CLR, BUSY, DONE});
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    recv_run = 1'b0;
    RSTXF    = 1'b0;
    START    = 1'b0;
    ABORT    = 1'b0;
    WIN_LOG2 = 6'd0;
    ERR_THR  = 32'd0;
    ERR_CNT  = 64'd0;
    RECV_CNT = 58'd0;
    test_reset();
    test_basic();
    test_errors();
    test_timeout();
    test_wrap();
    test_abort();
    test_clamp_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
